swd_host_ctrl: RTL and testbench

- Synthesizable SWD host sequencer for the debug path into the CM3 DAP.
- Accepts single DP/AP register transactions from a request port and serialises them onto SWCLK/SWDIO.
- Handles WAIT retry, read parity checking and the JTAG-to-SWD switch sequence.
- Sits between a bus-side debug agent (or test sequencer) and the MCU's SW-DP pins; behaviour on the wire matches the team's jlink SWD bench model.

---
 rtl/swd_host_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_swd_host_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swd_host_ctrl.sv
// SWD host sequencer: serialises single DP/AP transactions onto SWCLK/SWDIO with WAIT
// retry, read parity checking and the JTAG-to-SWD line initialisation sequence.
module swd_host_ctrl #(
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned MAX_WAIT_RETRY = 15,
    parameter int unsigned LRST_BITS      = 56,
    parameter int unsigned TAIL_BITS      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_apndp_i,
    input  logic        req_rnw_i,
    input  logic [1:0]  req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [2:0]  rsp_ack_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_perr_o,
    output logic        busy_o,
    output logic        swclk_o,
    output logic        swdio_o,
    output logic        swdio_oen_o,
    input  logic        swdio_i
);

    typedef enum logic [3:0] {
        StIdle, StLrst1, StSeq, StLrst2, StIdl0, StReq, StTrn1, StAck,
        StRdata, StTrnR, StTrnW, StWdata, StTail, StRsp
    } state_e;

    localparam int unsigned DivW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [15:0] JtagToSwd = 16'hE79E;
    localparam logic [2:0]  AckOk     = 3'b100;
    localparam logic [2:0]  AckWait   = 3'b010;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q;
    logic            half_q;
    logic [7:0]      bit_q;
    logic [7:0]      retry_q;
    logic            apndp_q, rnw_q;
    logic [1:0]      addr_q;
    logic [31:0]     wdata_q;
    logic [2:0]      ack_q;
    logic [31:0]     shift_q;
    logic            par_q;
    logic [2:0]      rsp_ack_q;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_perr_q;

    logic       running, div_end, sample_edge, bit_end, last_bit, accept;
    logic [7:0] bit_len;
    logic [7:0] req_bits;

    assign running     = (state_q != StIdle) && (state_q != StRsp);
    assign div_end     = div_q == DivW'(CLK_DIV - 1);
    // swdio_i is captured on the edge that raises swclk_o
    assign sample_edge = running && !half_q && div_end;
    assign bit_end     = running && half_q && div_end;
    assign last_bit    = bit_q == (bit_len - 8'd1);
    assign req_ready_o = (state_q == StIdle) && !init_i && !rst_i;
    assign accept      = req_valid_i && req_ready_o;

    // Wire order LSB first: start, APnDP, RnW, A2, A3, parity, stop, park
    assign req_bits = {1'b1, 1'b0, ^{apndp_q, rnw_q, addr_q}, addr_q[1], addr_q[0],
                       rnw_q, apndp_q, 1'b1};

    assign rsp_valid_o = state_q == StRsp;
    assign busy_o      = state_q != StIdle;
    assign rsp_ack_o   = rsp_ack_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_perr_o  = rsp_perr_q;

    always_comb begin
        bit_len = 8'd1;
        case (state_q)
            StLrst1, StLrst2: bit_len = 8'(LRST_BITS);
            StSeq:            bit_len = 8'd16;
            StIdl0, StReq:    bit_len = 8'd8;
            StAck:            bit_len = 8'd3;
            StRdata, StWdata: bit_len = 8'd33;
            StTail:           bit_len = 8'(TAIL_BITS);
            default:          bit_len = 8'd1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (state_q == StIdle) begin
            if (init_i) begin
                state_d = StLrst1;
            end else if (req_valid_i) begin
                state_d = StReq;
            end
        end else if (state_q == StRsp) begin
            state_d = StIdle;
        end else if (bit_end && last_bit) begin
            unique case (state_q)
                StLrst1: state_d = StSeq;
                StSeq:   state_d = StLrst2;
                StLrst2: state_d = StIdl0;
                StIdl0:  state_d = StIdle;
                StReq:   state_d = StTrn1;
                StTrn1:  state_d = StAck;
                StAck:   state_d = (ack_q == AckOk && rnw_q) ? StRdata : StTrnW;
                StRdata: state_d = StTrnR;
                StTrnR:  state_d = StTail;
                StTrnW:  state_d = (ack_q == AckOk) ? StWdata : StTail;
                StWdata: state_d = StTail;
                StTail:  state_d = (ack_q == AckWait && retry_q != 8'(MAX_WAIT_RETRY)) ?
                                   StReq : StRsp;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        swclk_o     = running && half_q;
        swdio_o     = 1'b0;
        swdio_oen_o = 1'b0;
        case (state_q)
            StLrst1, StLrst2: swdio_o = 1'b1;
            StSeq:            swdio_o = JtagToSwd[bit_q[3:0]];
            StReq:            swdio_o = req_bits[bit_q[2:0]];
            StWdata:          swdio_o = bit_q[5] ? ^wdata_q : wdata_q[bit_q[4:0]];
            StTrn1, StAck, StRdata, StTrnR, StTrnW: swdio_oen_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            div_q       <= '0;
            half_q      <= 1'b0;
            bit_q       <= '0;
            retry_q     <= '0;
            apndp_q     <= 1'b0;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ack_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            rsp_ack_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle) begin
                div_q  <= '0;
                half_q <= 1'b0;
                bit_q  <= '0;
                if (accept) begin
                    apndp_q <= req_apndp_i;
                    rnw_q   <= req_rnw_i;
                    addr_q  <= req_addr_i;
                    wdata_q <= req_wdata_i;
                    retry_q <= '0;
                end
            end else if (running) begin
                if (div_end) begin
                    div_q  <= '0;
                    half_q <= !half_q;
                end else begin
                    div_q <= div_q + DivW'(1);
                end
                if (bit_end) begin
                    bit_q <= last_bit ? 8'd0 : bit_q + 8'd1;
                end
                if (sample_edge && state_q == StAck) begin
                    ack_q <= {ack_q[1:0], swdio_i};
                end
                if (sample_edge && state_q == StRdata) begin
                    if (bit_q[5]) begin
                        par_q <= swdio_i;
                    end else begin
                        shift_q <= {swdio_i, shift_q[31:1]};
                    end
                end
                if (bit_end && last_bit && state_q == StTail) begin
                    if (state_d == StReq) begin
                        retry_q <= retry_q + 8'd1;
                    end else begin
                        rsp_ack_q  <= ack_q;
                        rsp_perr_q <= 1'b0;
                        if (ack_q == AckOk && rnw_q) begin
                            rsp_rdata_q <= shift_q;
                            rsp_perr_q  <= par_q != ^shift_q;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_swd_host_ctrl.sv
// Bench for swd_host_ctrl: a bit-level SWD target driven from per-transaction scripts, with
// the expected wire stream and response computed from the protocol rules.
module tb_swd_host_ctrl;

    localparam int unsigned CLK_DIV   = 2;
    localparam int unsigned MAX_RETRY = 3;
    localparam int unsigned LRST      = 56;
    localparam int unsigned TAIL      = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        init_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_apndp_i = 1'b0;
    logic        req_rnw_i = 1'b0;
    logic [1:0]  req_addr_i = 2'b00;
    logic [31:0] req_wdata_i = 32'h0;
    logic        swdio_i = 1'b1;
    logic        req_ready_o, rsp_valid_o, rsp_perr_o, busy_o;
    logic        swclk_o, swdio_o, swdio_oen_o;
    logic [2:0]  rsp_ack_o;
    logic [31:0] rsp_rdata_o;

    always #5 clk = ~clk;

    swd_host_ctrl #(
        .CLK_DIV        (CLK_DIV),
        .MAX_WAIT_RETRY (MAX_RETRY),
        .LRST_BITS      (LRST),
        .TAIL_BITS      (TAIL)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .init_i      (init_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_apndp_i (req_apndp_i),
        .req_rnw_i   (req_rnw_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ack_o   (rsp_ack_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_perr_o  (rsp_perr_o),
        .busy_o      (busy_o),
        .swclk_o     (swclk_o),
        .swdio_o     (swdio_o),
        .swdio_oen_o (swdio_oen_o),
        .swdio_i     (swdio_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor/target state, written only by the monitor block below
    int          nbit = 0;
    int          rsp_count = 0;
    int          acc_cyc = 0;
    int          rsp_cyc = 0;
    logic        rdy_at_rsp = 1'b0;
    logic        rdy_after_rsp = 1'b0;
    logic        prev_rsp = 1'b0;
    logic        swclk_prev = 1'b0;
    logic [2:0]  got_ack = 3'b0;
    logic [31:0] got_rdata = 32'h0;
    logic        got_perr = 1'b0;
    bit          obs_oen[$];
    bit          obs_dio[$];

    // Written by the stimulus process only
    int          base = 0;
    bit          tgt[$];
    bit          e_oen[$];
    bit          e_dio[$];
    bit          e_care[$];
    logic [2:0]  ack_script[$];
    logic [31:0] exp_rdata = 32'h0;

    always @(negedge clk) begin : mon
        int idx;
        if (!rst_i) begin
            if (prev_rsp) rdy_after_rsp = req_ready_o;
            prev_rsp = rsp_valid_o;
            if (rsp_valid_o) begin
                rsp_count++;
                rsp_cyc    = cyc;
                rdy_at_rsp = req_ready_o;
                got_ack    = rsp_ack_o;
                got_rdata  = rsp_rdata_o;
                got_perr   = rsp_perr_o;
            end
            if (req_valid_i && req_ready_o) acc_cyc = cyc;
            if (swclk_o && !swclk_prev) begin
                obs_oen.push_back(swdio_oen_o);
                obs_dio.push_back(swdio_o);
                nbit++;
                idx = nbit - base;
                swdio_i = (idx >= 0 && idx < tgt.size()) ? tgt[idx] : 1'b1;
            end
        end else begin
            prev_rsp = 1'b0;
        end
        swclk_prev = swclk_o;
    end

    function automatic void clear_model();
        tgt.delete();
        e_oen.delete();
        e_dio.delete();
        e_care.delete();
    endfunction

    function automatic void push_host(input bit v);
        e_oen.push_back(1'b0);
        e_dio.push_back(v);
        e_care.push_back(1'b1);
        tgt.push_back(1'($urandom_range(0, 1)));
    endfunction

    function automatic void push_tgt(input bit v);
        e_oen.push_back(1'b1);
        e_dio.push_back(1'b0);
        e_care.push_back(1'b0);
        tgt.push_back(v);
    endfunction

    task automatic check_wire(input string tag);
        int bad = 0;
        for (int i = 0; i < e_oen.size(); i++) begin
            if (base + i >= obs_oen.size()) begin
                bad++;
            end else if (obs_oen[base + i] != e_oen[i] ||
                         (e_care[i] && obs_dio[base + i] != e_dio[i])) begin
                bad++;
            end
        end
        check_eq({tag, "_nbits"}, 32'(nbit - base), 32'(e_oen.size()));
        check_eq({tag, "_wire_bad"}, 32'(bad), 32'd0);
    endtask

    // Builds the expected wire stream for a transaction and its target responses.
    function automatic logic [2:0] build_txn(input bit apndp, input bit rnw, input bit [1:0] addr,
                                             input bit [31:0] wdata, input bit [31:0] rdata,
                                             input bit corrupt);
        int          p = 0;
        bit          done = 1'b0;
        logic [2:0]  a = 3'b000;
        clear_model();
        while (!done) begin
            a = ack_script[(p < ack_script.size()) ? p : ack_script.size() - 1];
            push_host(1'b1); push_host(apndp); push_host(rnw);
            push_host(addr[0]); push_host(addr[1]);
            push_host(apndp ^ rnw ^ addr[0] ^ addr[1]);
            push_host(1'b0); push_host(1'b1);
            push_tgt(1'($urandom_range(0, 1)));
            push_tgt(a[2]); push_tgt(a[1]); push_tgt(a[0]);
            if (a == 3'b100 && rnw) begin
                for (int i = 0; i < 32; i++) push_tgt(rdata[i]);
                push_tgt((^rdata) ^ corrupt);
                push_tgt(1'($urandom_range(0, 1)));
            end else begin
                push_tgt(1'($urandom_range(0, 1)));
                if (a == 3'b100) begin
                    for (int i = 0; i < 32; i++) push_host(wdata[i]);
                    push_host(^wdata);
                end
            end
            for (int i = 0; i < TAIL; i++) push_host(1'b0);
            if (a == 3'b010 && p != MAX_RETRY) p++;
            else done = 1'b1;
        end
        return a;
    endfunction

    task automatic issue(input bit apndp, input bit rnw, input bit [1:0] addr,
                         input bit [31:0] wdata);
        int t = 0;
        @(posedge clk); #1;
        req_apndp_i = apndp;
        req_rnw_i   = rnw;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_valid_i = 1'b1;
        while (!req_ready_o && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        req_apndp_i = 1'($urandom_range(0, 1));
        req_rnw_i   = 1'($urandom_range(0, 1));
        req_addr_i  = 2'($urandom_range(0, 3));
        req_wdata_i = $urandom;
    endtask

    task automatic run_txn(input string tag, input bit apndp, input bit rnw, input bit [1:0] addr,
                           input bit [31:0] wdata, input bit [31:0] rdata, input bit corrupt);
        logic [2:0] fin;
        logic       exp_perr;
        logic [7:0] req_byte = 8'h0;
        int         rc0, t, lat;
        fin      = build_txn(apndp, rnw, addr, wdata, rdata, corrupt);
        exp_perr = 1'b0;
        if (fin == 3'b100 && rnw) begin
            exp_rdata = rdata;
            exp_perr  = corrupt;
        end
        lat  = e_oen.size() * 2 * CLK_DIV + 1;
        base = nbit;
        rc0  = rsp_count;
        issue(apndp, rnw, addr, wdata);
        t = 0;
        while (rsp_count == rc0 && t < lat + 100) begin
            @(posedge clk);
            t++;
        end
        repeat (6) @(posedge clk);
        check_eq({tag, "_rsp_count"}, 32'(rsp_count - rc0), 32'd1);
        check_eq({tag, "_latency"}, 32'(rsp_cyc - acc_cyc), 32'(lat));
        check_eq({tag, "_ack"}, 32'(got_ack), 32'(fin));
        check_eq({tag, "_rdata"}, got_rdata, exp_rdata);
        check_eq({tag, "_perr"}, 32'(got_perr), 32'(exp_perr));
        check_eq({tag, "_ready_in_rsp"}, 32'(rdy_at_rsp), 32'd0);
        check_eq({tag, "_ready_after"}, 32'(rdy_after_rsp), 32'd1);
        for (int i = 0; i < 8; i++) begin
            req_byte = {req_byte[6:0], (base + i < obs_dio.size()) ? obs_dio[base + i] : 1'b0};
        end
        check_eq({tag, "_req_byte"}, 32'(req_byte),
                 32'({1'b1, apndp, rnw, addr[0], addr[1], apndp ^ rnw ^ addr[0] ^ addr[1],
                      1'b0, 1'b1}));
        check_wire(tag);
    endtask

    task automatic run_init();
        logic [15:0] seq = 16'hE79E;
        int          rc0, t;
        clear_model();
        for (int i = 0; i < LRST; i++) push_host(1'b1);
        for (int i = 0; i < 16; i++) push_host(seq[i]);
        for (int i = 0; i < LRST; i++) push_host(1'b1);
        for (int i = 0; i < 8; i++) push_host(1'b0);
        base = nbit;
        rc0  = rsp_count;
        @(posedge clk); #1;
        init_i      = 1'b1;
        req_valid_i = 1'b1;  // init must win over a simultaneous request
        @(posedge clk); #1;
        init_i      = 1'b0;
        req_valid_i = 1'b0;
        t = 0;
        while (busy_o && t < 136 * 2 * CLK_DIV + 100) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (4) @(posedge clk);
        check_eq("init_busy_drop", 32'(busy_o), 32'd0);
        check_eq("init_no_rsp", 32'(rsp_count - rc0), 32'd0);
        check_wire("init");
    endtask

    task automatic run_reset_mid_wdata();
        logic [2:0] fin;
        int         rc0, t;
        ack_script = '{3'b100};
        fin  = build_txn(1'b1, 1'b0, 2'b01, 32'hA5A5_0F0F, 32'h0, 1'b0);
        base = nbit;
        rc0  = rsp_count;
        issue(1'b1, 1'b0, 2'b01, 32'hA5A5_0F0F);
        t = 0;
        while (nbit - base < 23 && t < 500) begin
            @(posedge clk);
            t++;
        end
        check_eq("rstmid_reached_wdata", 32'(t < 500), 32'd1);
        #1;
        check_eq("rstmid_oen_before", 32'(swdio_oen_o), 32'(fin == 3'b100 ? 0 : 1));
        rst_i = 1'b1;
        @(posedge clk); #1;
        check_eq("rstmid_swclk", 32'(swclk_o), 32'd0);
        check_eq("rstmid_dio", 32'({swdio_o, swdio_oen_o}), 32'd0);
        check_eq("rstmid_busy", 32'(busy_o), 32'd0);
        check_eq("rstmid_ready", 32'(req_ready_o), 32'd0);
        check_eq("rstmid_rsp", 32'({rsp_valid_o, rsp_ack_o, rsp_perr_o}), 32'd0);
        check_eq("rstmid_rdata", rsp_rdata_o, 32'h0);
        exp_rdata = 32'h0;
        rst_i = 1'b0;
        @(posedge clk); #1;
        check_eq("rstmid_ready_after", 32'(req_ready_o), 32'd1);
        repeat (300) @(posedge clk);
        check_eq("rstmid_no_rsp", 32'(rsp_count - rc0), 32'd0);
    endtask

    function automatic logic [2:0] rand_ack();
        int r = $urandom_range(0, 9);
        if (r < 5) return 3'b100;
        if (r < 7) return 3'b010;
        if (r == 7) return 3'b001;
        if (r == 8) return 3'b000;
        return 3'b111;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_ready", 32'(req_ready_o), 32'd0);
        check_eq("reset_pins", 32'({swclk_o, swdio_o, swdio_oen_o}), 32'd0);
        check_eq("reset_status", 32'({busy_o, rsp_valid_o, rsp_ack_o, rsp_perr_o}), 32'd0);
        check_eq("reset_rdata", rsp_rdata_o, 32'h0);
        rst_i = 1'b0;
        @(posedge clk); #1;
        check_eq("reset_ready_after", 32'(req_ready_o), 32'd1);

        run_init();

        ack_script = '{3'b100};
        run_txn("dp_rd_idr", 1'b0, 1'b1, 2'b00, 32'h0, 32'h2BA0_1477, 1'b0);
        ack_script = '{3'b100};
        run_txn("ap_wr", 1'b1, 1'b0, 2'b00, 32'h2300_0042, 32'h0, 1'b0);
        ack_script = '{3'b010, 3'b010, 3'b100};
        run_txn("ap_rd_wait2", 1'b1, 1'b1, 2'b11, 32'h0, 32'hDEAD_BEEF, 1'b0);
        ack_script = '{3'b010};
        run_txn("wait_forever", 1'b1, 1'b1, 2'b01, 32'h0, 32'h1234_5678, 1'b0);
        ack_script = '{3'b100};
        run_txn("bad_parity", 1'b0, 1'b1, 2'b10, 32'h0, 32'h8000_0001, 1'b1);
        ack_script = '{3'b001};
        run_txn("fault", 1'b1, 1'b1, 2'b10, 32'h0, 32'hFFFF_FFFF, 1'b0);

        run_reset_mid_wdata();

        for (int k = 0; k < 12; k++) begin
            int n = $urandom_range(1, 5);
            ack_script.delete();
            for (int j = 0; j < n; j++) ack_script.push_back(rand_ack());
            run_txn($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
